// File: rtl/cu_fsm_pkg.sv
// Shared types and constants for the OTTER control unit with interrupt support.
// No logic of its own; pure compile-time definitions.
// Not applicable: holds no state and exerts no flow control.
package cu_fsm_pkg;

  // Control-unit phases: one instruction is FETCH -> EXEC [-> WB] [-> TRAP].
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_TRAP  = 3'd4
  } cu_state_t;

  // RV32I major opcodes (instruction bits [6:0]).
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Datapath strobes driven by the control unit, grouped so the decode can
  // clear them all with a single default.
  typedef struct packed {
    logic pc_write;
    logic reg_wr;
    logic mem_we2;
    logic mem_rden1;
    logic mem_rden2;
    logic csr_we;
    logic mret_exec;
    logic int_taken;
    logic bus_err;
  } cu_strobes_t;

  // Opcodes that retire in EXEC by writing rd and advancing the PC.
  function automatic logic writes_rd_in_exec(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
        writes_rd_in_exec = 1'b1;
      default:
        writes_rd_in_exec = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/irq_pending.sv
// Interrupt front end: rising-edge capture, sticky pending bits, mask and lowest-index priority select.
// Edge to pending bit: 1 cycle; any_pending/sel_id are combinational from the pending register.
// No backpressure: pending bits are held until their channel is taken (take strobe), never dropped.
module irq_pending #(
  parameter int NUM_IRQ = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_IRQ-1:0]                 irq,
  input  logic [NUM_IRQ-1:0]                 irq_mask,
  input  logic                               take,
  output logic                               any_pending,
  output logic [$clog2(NUM_IRQ + 1)-1:0]     sel_id
);

  localparam int ID_W = $clog2(NUM_IRQ + 1);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] sel_oh;
  logic [NUM_IRQ-1:0] clr;

  assign rise        = irq & ~irq_q;
  assign active      = pend_q & irq_mask;
  assign any_pending = |active;

  // Isolate the lowest set bit: that channel is the one a trap will service.
  assign sel_oh = active & (~active + 1'b1);

  // A take only clears the channel actually selected; with nothing active it is a no-op.
  assign clr = take ? sel_oh : '0;

  // Binary index of the lowest-numbered active channel (0 when none).
  always_comb begin
    sel_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel_id = ID_W'(i);
      end
    end
  end

  // Edge history and sticky pending bits; a fresh edge overrides a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq;
      pend_q <= (pend_q & ~clr) | rise;
    end
  end

endmodule

// File: rtl/otter_cu_fsm_irq.sv
// OTTER multicycle control unit: FETCH/EXEC/WB sequencing with interrupt and bus-error traps.
// Strobes are decoded combinationally from the current state (plus opcode/ack); no registered output delay.
// Memory stalls by withholding mem_ack; after ACK_TIMEOUT wait cycles the access is abandoned as a bus error.
module otter_cu_fsm_irq
  import cu_fsm_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     funct3,
  input  logic                           mem_ack,
  input  logic                           mie,
  input  logic [NUM_IRQ-1:0]             irq,
  input  logic [NUM_IRQ-1:0]             irq_mask,
  output logic                           pc_write,
  output logic                           reg_wr,
  output logic                           mem_we2,
  output logic                           mem_rden1,
  output logic                           mem_rden2,
  output logic                           csr_we,
  output logic                           mret_exec,
  output logic                           int_taken,
  output logic                           bus_err,
  output logic [$clog2(NUM_IRQ + 1)-1:0] trap_id
);

  localparam int ID_W  = $clog2(NUM_IRQ + 1);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);
  localparam logic [ID_W-1:0]  BERR_ID   = ID_W'(NUM_IRQ);

  cu_state_t        state_q;
  cu_state_t        state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             berr_q;

  logic             any_pending;
  logic [ID_W-1:0]  sel_id;
  logic             take;
  logic             timeout;
  logic             irq_go;
  cu_strobes_t      strb;

  assign timeout = (wait_cnt_q == CNT_LIMIT);
  assign irq_go  = mie & any_pending;

  irq_pending #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_pending (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq         (irq),
    .irq_mask    (irq_mask),
    .take        (take),
    .any_pending (any_pending),
    .sel_id      (sel_id)
  );

  // State, wait counter, and a one-cycle memo that the coming TRAP is a bus error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      wait_cnt_q <= '0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      berr_q     <= strb.bus_err;
    end
  end

  // Next-state and strobe decode; completions divert to TRAP when an enabled interrupt waits.
  always_comb begin
    state_d = state_q;
    strb    = '0;
    trap_id = '0;
    take    = 1'b0;

    case (state_q)
      ST_INIT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        strb.mem_rden1 = 1'b1;
        if (mem_ack) begin
          state_d = ST_EXEC;
        end else if (timeout) begin
          strb.bus_err = 1'b1;
          state_d      = ST_TRAP;
        end
      end

      ST_EXEC: begin
        state_d = irq_go ? ST_TRAP : ST_FETCH;
        case (opcode)
          OPC_LOAD: begin
            strb.mem_rden2 = 1'b1;
            state_d        = ST_WB;
          end
          OPC_STORE: begin
            strb.mem_we2  = 1'b1;
            strb.pc_write = 1'b1;
          end
          OPC_BRANCH: begin
            strb.pc_write = 1'b1;
          end
          OPC_SYSTEM: begin
            strb.pc_write = 1'b1;
            if (funct3 != 3'b000) begin
              strb.csr_we = 1'b1;
              strb.reg_wr = 1'b1;
            end else begin
              strb.mret_exec = 1'b1;
            end
          end
          default: begin
            // ALU/jump class writes rd; anything unrecognised just advances the PC.
            strb.pc_write = 1'b1;
            strb.reg_wr   = writes_rd_in_exec(opcode);
          end
        endcase
      end

      ST_WB: begin
        strb.mem_rden2 = 1'b1;
        if (mem_ack) begin
          strb.reg_wr   = 1'b1;
          strb.pc_write = 1'b1;
          state_d       = irq_go ? ST_TRAP : ST_FETCH;
        end else if (timeout) begin
          strb.bus_err = 1'b1;
          state_d      = ST_TRAP;
        end
      end

      ST_TRAP: begin
        strb.int_taken = 1'b1;
        strb.pc_write  = 1'b1;
        state_d        = ST_FETCH;
        if (berr_q) begin
          // Bus errors report their own cause and leave interrupt state alone.
          trap_id = BERR_ID;
        end else begin
          trap_id = sel_id;
          take    = 1'b1;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Wait counter: restarts on every state change, counts while stalled in FETCH or WB.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_d == state_q) && ((state_q == ST_FETCH) || (state_q == ST_WB))) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  assign pc_write  = strb.pc_write;
  assign reg_wr    = strb.reg_wr;
  assign mem_we2   = strb.mem_we2;
  assign mem_rden1 = strb.mem_rden1;
  assign mem_rden2 = strb.mem_rden2;
  assign csr_we    = strb.csr_we;
  assign mret_exec = strb.mret_exec;
  assign int_taken = strb.int_taken;
  assign bus_err   = strb.bus_err;

endmodule

// File: tb/tb_otter_cu_fsm_irq.sv
// Bench for otter_cu_fsm_irq: directed scenarios then random traffic, scored against a cycle model.
// Expected strobe vectors are queued at stimulus time and popped by an independent monitor.
// Memory stalls are emulated by holding mem_ack low for chosen or random stretches.
module tb_otter_cu_fsm_irq;

  localparam int N   = 4;
  localparam int TO  = 15;
  localparam int IDW = $clog2(N + 1);
  localparam int OW  = 9 + IDW;

  localparam bit [6:0] LOAD   = 7'b0000011;
  localparam bit [6:0] ADDI   = 7'b0010011;
  localparam bit [6:0] SYSOP  = 7'b1110011;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic           mem_ack;
  logic           mie;
  logic [N-1:0]   irq;
  logic [N-1:0]   irq_mask;
  logic           pc_write, reg_wr, mem_we2, mem_rden1, mem_rden2;
  logic           csr_we, mret_exec, int_taken, bus_err;
  logic [IDW-1:0] trap_id;

  always #5 clk = ~clk;

  otter_cu_fsm_irq #(
    .NUM_IRQ     (N),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct3    (funct3),
    .mem_ack   (mem_ack),
    .mie       (mie),
    .irq       (irq),
    .irq_mask  (irq_mask),
    .pc_write  (pc_write),
    .reg_wr    (reg_wr),
    .mem_we2   (mem_we2),
    .mem_rden1 (mem_rden1),
    .mem_rden2 (mem_rden2),
    .csr_we    (csr_we),
    .mret_exec (mret_exec),
    .int_taken (int_taken),
    .bus_err   (bus_err),
    .trap_id   (trap_id)
  );

  // ---------------- reference model ----------------
  localparam int PH_BOOT = 0, PH_FETCH = 1, PH_EXEC = 2, PH_WB = 3, PH_TRAP = 4;

  int         ph;
  int         waited;
  bit         fault;
  bit [N-1:0] pend;
  bit [N-1:0] last_irq;

  // Inputs currently applied to the DUT (what it samples at the next edge).
  bit         a_rst;
  bit [6:0]   a_op;
  bit [2:0]   a_f3;
  bit         a_ack;
  bit         a_mie;
  bit [N-1:0] a_irq;
  bit [N-1:0] a_mask;

  // Inputs the stimulus wants for the next cycle.
  bit         drv_rst;
  bit [6:0]   drv_op;
  bit [2:0]   drv_f3;
  bit         drv_ack;
  bit         drv_mie;
  bit [N-1:0] drv_irq;
  bit [N-1:0] drv_mask;

  int ack_mode;   // 0: drv_ack as set, 1: ack after dly_* wait cycles in FETCH/WB
  int dly_if;
  int dly_wb;

  bit [OW-1:0] exp_q[$];
  int n_vec;
  int n_bad;

  bit [6:0] op_tab [11] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                            7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                            7'b1100111, 7'b1110011, 7'b0001111};

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit retires_with_rd(input bit [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  endfunction

  function automatic void model_reset();
    ph = PH_BOOT; waited = 0; fault = 1'b0; pend = '0; last_irq = '0;
  endfunction

  // Strobes the spec requires for the current cycle.
  function automatic bit [OW-1:0] model_out();
    bit pc, rg, we, r1, r2, cs, mr, it, be;
    int id;
    {pc, rg, we, r1, r2, cs, mr, it, be} = '0;
    id = 0;
    case (ph)
      PH_FETCH: begin r1 = 1; be = !a_ack && (waited == TO); end
      PH_EXEC: begin
        if (a_op == LOAD) r2 = 1;
        else if (a_op == 7'b0100011) begin we = 1; pc = 1; end
        else if (a_op == SYSOP) begin pc = 1; if (a_f3 != 0) begin cs = 1; rg = 1; end else mr = 1; end
        else begin pc = 1; rg = retires_with_rd(a_op); end
      end
      PH_WB: begin
        r2 = 1;
        if (a_ack) begin rg = 1; pc = 1; end
        else be = (waited == TO);
      end
      PH_TRAP: begin
        it = 1; pc = 1;
        id = fault ? N : lowest(pend & a_mask);
        if (id < 0) id = 0;
      end
      default: ;
    endcase
    return {pc, rg, we, r1, r2, cs, mr, it, be, IDW'(id)};
  endfunction

  // Advance the model across one rising edge using the inputs held during the cycle.
  function automatic void model_clock();
    int nxt, nwait, k;
    bit nfault, done;
    bit [N-1:0] clr;
    if (!a_rst) return;
    nxt = ph; nwait = 0; nfault = 0; done = 0; clr = '0;
    case (ph)
      PH_BOOT:  nxt = PH_FETCH;
      PH_FETCH: if (a_ack) nxt = PH_EXEC;
                else if (waited == TO) begin nxt = PH_TRAP; nfault = 1; end
                else nwait = waited + 1;
      PH_EXEC:  if (a_op == LOAD) nxt = PH_WB; else done = 1;
      PH_WB:    if (a_ack) done = 1;
                else if (waited == TO) begin nxt = PH_TRAP; nfault = 1; end
                else nwait = waited + 1;
      PH_TRAP: begin
        nxt = PH_FETCH;
        if (!fault) begin k = lowest(pend & a_mask); if (k >= 0) clr[k] = 1; end
      end
      default: nxt = PH_BOOT;
    endcase
    if (done) nxt = (a_mie && ((pend & a_mask) != 0)) ? PH_TRAP : PH_FETCH;
    pend     = (pend & ~clr) | (a_irq & ~last_irq);
    last_irq = a_irq;
    ph = nxt; waited = nwait; fault = nfault;
  endfunction

  // One clock cycle of stimulus; the expected response is queued for the monitor.
  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    if (ack_mode == 1) begin
      case (ph)
        PH_FETCH: drv_ack = (waited >= dly_if);
        PH_WB:    drv_ack = (waited >= dly_wb);
        default:  drv_ack = 1'($urandom_range(0, 1));
      endcase
    end
    rst_n = drv_rst; opcode = drv_op; funct3 = drv_f3; mem_ack = drv_ack;
    mie = drv_mie; irq = drv_irq; irq_mask = drv_mask;
    a_rst = drv_rst; a_op = drv_op; a_f3 = drv_f3; a_ack = drv_ack;
    a_mie = drv_mie; a_irq = drv_irq; a_mask = drv_mask;
    if (!drv_rst) model_reset();
    exp_q.push_back(model_out());
  endtask

  // Monitor: every cycle presents one strobe vector; compare it mid-cycle.
  initial begin
    logic [OW-1:0] act;
    bit   [OW-1:0] exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {pc_write, reg_wr, mem_we2, mem_rden1, mem_rden2, csr_we,
               mret_exec, int_taken, bus_err, trap_id};
        n_vec++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL strobes @%0t: got %b, required %b (pc,rw,we2,rd1,rd2,csr,mret,int,berr,id)",
                   $time, act, exp);
        end
      end
    end
  end

  initial begin
    int no_ack_run;
    n_vec = 0; n_bad = 0; no_ack_run = 0;
    drv_rst = 0; drv_op = ADDI; drv_f3 = 0; drv_ack = 0; drv_mie = 0;
    drv_irq = '0; drv_mask = '1;
    rst_n = 0; opcode = ADDI; funct3 = 0; mem_ack = 0; mie = 0; irq = '0; irq_mask = '1;
    a_rst = 0; a_op = ADDI; a_f3 = 0; a_ack = 0; a_mie = 0; a_irq = '0; a_mask = '1;
    model_reset();
    ack_mode = 1; dly_if = 0; dly_wb = 0;

    // Reset state.
    repeat (3) tick();
    drv_rst = 1;
    // ADDI with ack on the first fetch cycle.
    repeat (6) tick();
    // LW acknowledged three cycles into WB.
    drv_op = LOAD; dly_wb = 3;
    repeat (12) tick();
    // Two channels rise together: traps for 1 then 3.
    drv_op = ADDI; dly_wb = 0; drv_mie = 1; drv_mask = '1;
    tick();
    drv_irq = 4'b1010;
    repeat (14) tick();
    drv_irq = '0;
    // Fetch never acknowledged: bus error with no interrupts waiting.
    dly_if = 1000;
    repeat (20) tick();
    dly_if = 0;
    repeat (4) tick();
    // Bus error while a masked interrupt waits; it must survive and fire once unmasked.
    drv_mask = 4'b0000; drv_irq = 4'b0100;
    repeat (3) tick();
    dly_if = 1000;
    repeat (20) tick();
    dly_if = 0; drv_mask = '1;
    repeat (8) tick();
    drv_irq = '0;
    // Interrupt raised with MIE clear is retained until MIE is set.
    drv_mie = 0; drv_irq = 4'b0001;
    repeat (8) tick();
    drv_mie = 1;
    repeat (6) tick();
    drv_irq = '0;
    // Reset in the middle of a load's WB with an interrupt pending.
    drv_mie = 0; drv_irq = 4'b1000; drv_op = LOAD; dly_wb = 10;
    for (int k = 0; k < 30 && !(ph == PH_WB && waited >= 2); k++) tick();
    drv_rst = 0; drv_irq = '0;
    repeat (2) tick();
    drv_rst = 1; drv_mie = 1; drv_op = ADDI; dly_wb = 0;
    repeat (10) tick();

    // Random traffic.
    ack_mode = 0;
    for (int t = 0; t < 3000; t++) begin
      if (no_ack_run == 0 && $urandom_range(0, 199) == 0) no_ack_run = $urandom_range(10, 40);
      if (no_ack_run > 0) begin drv_ack = 0; no_ack_run--; end
      else drv_ack = ($urandom_range(0, 2) != 0);
      drv_op = ($urandom_range(0, 11) == 11) ? 7'($urandom) : op_tab[$urandom_range(0, 10)];
      drv_f3 = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 15) == 0) drv_irq[b] = ~drv_irq[b];
      if ($urandom_range(0, 39) == 0) drv_mie = ~drv_mie;
      if ($urandom_range(0, 49) == 0) drv_mask = N'($urandom);
      drv_rst = ($urandom_range(0, 599) != 0);
      tick();
    end
    drv_rst = 1;
    tick();

    // Let the monitor drain the last queued vectors.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
